// File: rtl/line_scanner.sv
// line_scanner: scans a latched ROWS x COLS board for WIN_LEN runs, one anchor cell per cycle.
// Threat counting is built only when LINE_SCANNER_THREAT_EN is defined.
module line_scanner #(
   parameter int ROWS    = 6,
   parameter int COLS    = 7,
   parameter int WIN_LEN = 4,
   parameter int CNT_W   = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [ROWS*COLS*2-1:0]  panel,
   output logic                    busy,
   output logic                    done,
   output logic [1:0]              winner,
   output logic [$clog2(ROWS)-1:0] win_row,
   output logic [$clog2(COLS)-1:0] win_col,
   output logic [1:0]              win_dir,
   output logic [CNT_W-1:0]        threats_p1,
   output logic [CNT_W-1:0]        threats_p2
);

   localparam int BW = ROWS*COLS*2;
   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);
   localparam int IW = $clog2(BW);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]    state_r;
   logic [BW-1:0] board_r;
   logic [RW-1:0] row_r;
   logic [CW-1:0] col_r;

   logic [3:0] run1_s;
   logic [3:0] run2_s;
   logic [3:0] hit_s;
   logic [1:0] first_dir_s;
   logic       inb_s;
   int         n1_s;
   int         n2_s;
`ifdef LINE_SCANNER_THREAT_EN
   logic [3:0] thr1_s;
   logic [3:0] thr2_s;
`endif

   // Off-board coordinates read as empty so window loops never index outside the board.
   function automatic logic [1:0] cell_at(input logic [BW-1:0] b, input int rr, input int cc);
      logic [1:0] v;
      if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) v = 2'b00;
      else v = b[IW'((rr*COLS + cc)*2) +: 2];
      return v;
   endfunction

   function automatic void count_dir(input logic [BW-1:0] b, input int rr, input int cc,
                                     input logic [1:0] d, output logic inb,
                                     output int n1, output int n2);
      int dr;
      int dc;
      case (d)
         2'd0:    begin dr = 0;  dc = 1; end
         2'd1:    begin dr = 1;  dc = 0; end
         2'd2:    begin dr = 1;  dc = 1; end
         2'd3:    begin dr = -1; dc = 1; end
         default: begin dr = 0;  dc = 1; end
      endcase
      inb = (rr + dr*(WIN_LEN-1) >= 0) && (rr + dr*(WIN_LEN-1) < ROWS) &&
            (cc + dc*(WIN_LEN-1) < COLS);
      n1 = 0;
      n2 = 0;
      for (int k = 0; k < WIN_LEN; k++) begin
         case (cell_at(b, rr + dr*k, cc + dc*k))
            2'b01:   n1 = n1 + 1;
            2'b10:   n2 = n2 + 1;
            default: n1 = n1 + 0;
         endcase
      end
   endfunction

   // Evaluate the four windows of the current anchor.
   always_comb begin
      run1_s = 4'b0000;
      run2_s = 4'b0000;
      inb_s  = 1'b0;
      n1_s   = 0;
      n2_s   = 0;
`ifdef LINE_SCANNER_THREAT_EN
      thr1_s = 4'b0000;
      thr2_s = 4'b0000;
`endif
      for (int d = 0; d < 4; d++) begin
         count_dir(board_r, int'(row_r), int'(col_r), 2'(d), inb_s, n1_s, n2_s);
         run1_s[2'(d)] = inb_s && (n1_s == WIN_LEN);
         run2_s[2'(d)] = inb_s && (n2_s == WIN_LEN);
`ifdef LINE_SCANNER_THREAT_EN
         // WIN_LEN-1 of one player with none of the other leaves exactly one empty cell.
         thr1_s[2'(d)] = inb_s && (n1_s == WIN_LEN-1) && (n2_s == 0);
         thr2_s[2'(d)] = inb_s && (n2_s == WIN_LEN-1) && (n1_s == 0);
`endif
      end
   end

   // First run direction of this anchor in H, V, D, A order.
   always_comb begin
      hit_s = run1_s | run2_s;
      if (hit_s[0])      first_dir_s = 2'd0;
      else if (hit_s[1]) first_dir_s = 2'd1;
      else if (hit_s[2]) first_dir_s = 2'd2;
      else if (hit_s[3]) first_dir_s = 2'd3;
      else               first_dir_s = 2'd0;
   end

   // Control FSM, anchor walk and run result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         board_r <= {BW{1'b0}};
         row_r   <= {RW{1'b0}};
         col_r   <= {CW{1'b0}};
         busy    <= 1'b0;
         done    <= 1'b0;
         winner  <= 2'b00;
         win_row <= {RW{1'b0}};
         win_col <= {CW{1'b0}};
         win_dir <= 2'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  board_r <= panel;
                  row_r   <= {RW{1'b0}};
                  col_r   <= {CW{1'b0}};
                  winner  <= 2'b00;
                  win_row <= {RW{1'b0}};
                  win_col <= {CW{1'b0}};
                  win_dir <= 2'd0;
                  busy    <= 1'b1;
                  state_r <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               winner <= winner | {|run2_s, |run1_s};
               if (winner == 2'b00 && hit_s != 4'b0000) begin
                  win_row <= row_r;
                  win_col <= col_r;
                  win_dir <= first_dir_s;
               end
               if (col_r == CW'(COLS-1)) begin
                  col_r <= {CW{1'b0}};
                  if (row_r == RW'(ROWS-1)) begin
                     done    <= 1'b1;
                     state_r <= ST_DONE;
                  end else begin
                     row_r <= row_r + RW'(1);
                  end
               end else begin
                  col_r <= col_r + CW'(1);
               end
            end
            ST_DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef LINE_SCANNER_THREAT_EN
   logic [CNT_W-1:0] cnt_p1_r;
   logic [CNT_W-1:0] cnt_p2_r;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] hits);
      logic [CNT_W+2:0] s;
      s = {3'b000, a} + (CNT_W+3)'(hits[0]) + (CNT_W+3)'(hits[1]) +
          (CNT_W+3)'(hits[2]) + (CNT_W+3)'(hits[3]);
      if (s > (CNT_W+3)'({CNT_W{1'b1}})) return {CNT_W{1'b1}};
      else return s[CNT_W-1:0];
   endfunction

   // Saturating threat counters, cleared on an accepted start.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_p1_r <= {CNT_W{1'b0}};
         cnt_p2_r <= {CNT_W{1'b0}};
      end else if (state_r == ST_IDLE && start) begin
         cnt_p1_r <= {CNT_W{1'b0}};
         cnt_p2_r <= {CNT_W{1'b0}};
      end else if (state_r == ST_SCAN) begin
         cnt_p1_r <= sat_add(cnt_p1_r, thr1_s);
         cnt_p2_r <= sat_add(cnt_p2_r, thr2_s);
      end else begin
         cnt_p1_r <= cnt_p1_r;
         cnt_p2_r <= cnt_p2_r;
      end
   end

   assign threats_p1 = cnt_p1_r;
   assign threats_p2 = cnt_p2_r;
`else
   assign threats_p1 = {CNT_W{1'b0}};
   assign threats_p2 = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/line_scanner.md
LINE_SCANNER -- requirements
Module: line_scanner

Interface
REQ-001 Parameter ROWS, default 6: board rows; row 0 is the bottom row.
REQ-002 Parameter COLS, default 7: board columns.
REQ-003 Parameter WIN_LEN, default 4: run length that wins; legal range 2 <= WIN_LEN <= min(ROWS,COLS).
REQ-004 Parameter CNT_W, default 8: threat counter width.
REQ-005 Port clk, input, 1: the single clock; one clock domain, all logic on rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port start, input, 1: request a scan of panel.
REQ-008 Port panel, input, ROWS*COLS*2: cell (r,c) at bits [(r*COLS+c)*2 +: 2]; 00 empty, 01 player 1, 10 player 2, 11 treated as empty.
REQ-009 Port busy, output, 1: high while a scan is in progress.
REQ-010 Port done, output, 1: single-cycle pulse when results are valid.
REQ-011 Port winner, output, 2: bit0 = player 1 has a run, bit1 = player 2 has a run.
REQ-012 Port win_row, output, $clog2(ROWS): anchor row of first run found.
REQ-013 Port win_col, output, $clog2(COLS): anchor column of first run found.
REQ-014 Port win_dir, output, 2: direction of first run found; 0 H (c+k), 1 V (r+k), 2 D (r+k,c+k), 3 A (r-k,c+k).
REQ-015 Ports threats_p1 and threats_p2, output, CNT_W each: threat window counts per player.

Function
REQ-016 FSM states: IDLE, SCAN, DONE.
REQ-017 IDLE: start=1 latches panel into an internal copy, clears all result outputs, zeroes the anchor index, and moves to SCAN.
REQ-018 SCAN: one anchor cell per cycle, row-major (r=0..ROWS-1, c=0..COLS-1); exactly ROWS*COLS cycles.
REQ-019 Per anchor, each direction is evaluated in order H, V, D, A over WIN_LEN cells from the anchor; windows leaving the board are skipped.
REQ-020 Run: all WIN_LEN cells equal 01 (player 1) or all equal 10 (player 2); sets the corresponding winner bit (OR-accumulated).
REQ-021 win_row, win_col and win_dir capture only the first run in scan and direction order, then hold for the rest of the scan.
REQ-022 Threat: exactly WIN_LEN-1 cells belong to one player and the remaining cell is empty; adds 1 to that player's counter per window.
REQ-023 Threat counters saturate at 2^CNT_W-1.
REQ-024 After the last anchor the FSM enters DONE for one cycle with done=1, then returns to IDLE.
REQ-025 Latency: start accepted on cycle 0 gives done=1 on cycle ROWS*COLS+1; with defaults this is cycle 43.
REQ-026 busy=1 in SCAN and DONE; busy=0 in IDLE.
REQ-027 start is ignored in SCAN and DONE; changes to panel after the latch do not affect the scan.
REQ-028 Results hold from done until the next accepted start.
REQ-029 No run found: winner=00 and win_row=win_col=win_dir=0.

Reset
REQ-030 rst=1 forces IDLE on the next edge from any state, including mid-scan; the aborted scan produces no done pulse.
REQ-031 Reset values: busy=0, done=0, winner=00, win_row=0, win_col=0, win_dir=0, threats_p1=0, threats_p2=0; anchor index and board copy cleared.
REQ-032 rst has priority over start in the same cycle.

Configuration
REQ-033 Macro LINE_SCANNER_THREAT_EN defined: threat detection and counters are built as in REQ-022/023.
REQ-034 Macro LINE_SCANNER_THREAT_EN undefined: no threat logic is built; threats_p1 and threats_p2 are tied to 0; all other behaviour, including timing, is unchanged.

Verification (defaults 6x7, WIN_LEN=4)
REQ-035 Empty board, start on cycle 0 -> busy on cycles 1-43, done only on cycle 43, winner=00, both threat counts 0.
REQ-036 Player 1 at (0,0)-(0,3) -> winner=01, win_row=0, win_col=0, win_dir=0.
REQ-037 Player 1 at (0,0),(0,1),(0,2) only -> winner=00; threats_p1=1 with the macro, 0 without.
REQ-038 Player 2 at (3,0),(2,1),(1,2),(0,3) -> winner=10, win_row=3, win_col=0, win_dir=3.
REQ-039 Start pulses during SCAN with panel changed -> ignored; results match the latched board; exactly one done.
REQ-040 rst asserted on the 20th SCAN cycle -> IDLE next cycle, all outputs 0, no done; a new start then completes normally in 43 cycles.
